// File: rtl/biphase_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : biphase_rx_framer
// Brief    : Frame controller behind the biphase-to-NRZ decoder. It hunts for
//            idle-line lock, assembles start/data/stop frames into a FWFT FIFO,
//            and reports lock, frame errors and overflow. Define
//            BIPHASE_RX_PARITY_EN to add an even-parity bit after the data.
// Revision : 1.0  initial release
// ============================================================================
module biphase_rx_framer #(
    parameter int DATA_BITS    = 8,
    parameter int IDLE_BITS    = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int GLITCH_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 bit_valid,
    input  logic                 bit_data,
    input  logic                 bit_ferr,
    input  logic                 bit_glitch,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 locked,
    output logic                 frame_error,
    output logic                 overflow,
    output logic [7:0]           err_count,
    input  logic                 clear_errors
);

    localparam int C_IDLE_W = $clog2(IDLE_BITS + 1);
    localparam int C_IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int C_GLT_W  = $clog2(GLITCH_LIMIT + 2);
    localparam int C_ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int C_PTR_W  = C_ADDR_W + 1;

    localparam logic [C_IDLE_W-1:0] C_IDLE_LAST  = C_IDLE_W'(IDLE_BITS - 1);
    localparam logic [C_IDX_W-1:0]  C_LAST_IDX   = C_IDX_W'(DATA_BITS - 1);
    localparam logic [C_GLT_W-1:0]  C_GLITCH_MAX = C_GLT_W'(GLITCH_LIMIT);

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_IDLE   = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [C_IDLE_W-1:0]    r_idle_cnt;
    logic [C_IDLE_W-1:0]    w_idle_cnt_next;
    logic [C_IDX_W-1:0]     r_bit_idx;
    logic [C_IDX_W-1:0]     w_bit_idx_next;
    logic [C_GLT_W-1:0]     r_glitch_cnt;
    logic [C_GLT_W-1:0]     w_glitch_cnt_next;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [DATA_BITS-1:0]   w_shreg_next;
    logic                   w_push;
    logic                   w_fe;
    logic                   w_in_frame;
    logic                   w_glitch_over;
    logic                   w_ferr;

    logic                   r_locked;
    logic                   r_frame_error;
    logic                   r_overflow;
    logic [7:0]             r_err_count;

    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]     r_wr_ptr;
    logic [C_PTR_W-1:0]     r_rd_ptr;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_wr_en;
    logic                   w_drop;

    assign w_in_frame    = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);
    // A glitch that would push the count past the limit aborts the frame like a decoder ferr.
    assign w_glitch_over = w_in_frame && bit_glitch && (r_glitch_cnt == C_GLITCH_MAX);
    assign w_ferr        = bit_ferr || w_glitch_over;

    always_comb begin
        w_state_next      = r_state;
        w_idle_cnt_next   = r_idle_cnt;
        w_bit_idx_next    = r_bit_idx;
        w_glitch_cnt_next = r_glitch_cnt;
        w_shreg_next      = r_shreg;
        w_push            = 1'b0;
        w_fe              = 1'b0;

        if (!enable) begin
            w_state_next      = S_HUNT;
            w_idle_cnt_next   = '0;
            w_bit_idx_next    = '0;
            w_glitch_cnt_next = '0;
        end else if (w_ferr) begin
            w_idle_cnt_next = '0;
            if (r_state != S_HUNT) begin
                w_fe              = 1'b1;
                w_state_next      = S_HUNT;
                w_bit_idx_next    = '0;
                w_glitch_cnt_next = '0;
            end
        end else begin
            if (w_in_frame && bit_glitch) begin
                w_glitch_cnt_next = r_glitch_cnt + C_GLT_W'(1);
            end
            if (bit_valid) begin
                case (r_state)
                    S_HUNT: begin
                        if (!bit_data) begin
                            w_idle_cnt_next = '0;
                        end else if (r_idle_cnt == C_IDLE_LAST) begin
                            w_state_next    = S_IDLE;
                            w_idle_cnt_next = '0;
                        end else begin
                            w_idle_cnt_next = r_idle_cnt + C_IDLE_W'(1);
                        end
                    end
                    S_IDLE: begin
                        if (!bit_data) begin
                            w_state_next      = S_DATA;
                            w_bit_idx_next    = '0;
                            w_glitch_cnt_next = '0;
                            w_shreg_next      = '0;
                        end
                    end
                    S_DATA: begin
                        w_shreg_next[r_bit_idx] = bit_data;
                        w_bit_idx_next          = r_bit_idx + C_IDX_W'(1);
                        if (r_bit_idx == C_LAST_IDX) begin
`ifdef BIPHASE_RX_PARITY_EN
                            w_state_next = S_PARITY;
`else
                            w_state_next = S_STOP;
`endif
                        end
                    end
`ifdef BIPHASE_RX_PARITY_EN
                    S_PARITY: begin
                        if (bit_data == (^r_shreg)) begin
                            w_state_next = S_STOP;
                        end else begin
                            w_fe         = 1'b1;
                            w_state_next = S_HUNT;
                        end
                    end
`endif
                    S_STOP: begin
                        if (bit_data) begin
                            w_push       = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_fe         = 1'b1;
                            w_state_next = S_HUNT;
                        end
                    end
                    default: begin
                        w_state_next = S_HUNT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_HUNT;
            r_idle_cnt    <= '0;
            r_bit_idx     <= '0;
            r_glitch_cnt  <= '0;
            r_shreg       <= '0;
            r_locked      <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idle_cnt    <= w_idle_cnt_next;
            r_bit_idx     <= w_bit_idx_next;
            r_glitch_cnt  <= w_glitch_cnt_next;
            r_shreg       <= w_shreg_next;
            r_locked      <= (w_state_next != S_HUNT);
            r_frame_error <= w_fe;
        end
    end

    // Error reporting: clear_errors takes priority over a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst || clear_errors) begin
            r_err_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_fe && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[C_ADDR_W] != r_rd_ptr[C_ADDR_W]) &&
                     (r_wr_ptr[C_ADDR_W-1:0] == r_rd_ptr[C_ADDR_W-1:0]);
    assign w_pop   = !w_empty && rx_ready;
    // When full, the slot being written is the one being popped this cycle.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[C_ADDR_W-1:0]] <= r_shreg;
        end
    end

    assign rx_data     = w_empty ? '0 : r_mem[r_rd_ptr[C_ADDR_W-1:0]];
    assign rx_valid    = !w_empty;
    assign locked      = r_locked;
    assign frame_error = r_frame_error;
    assign overflow    = r_overflow;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: doc/biphase_rx_framer.md
# biphase_rx_framer

Frame controller that sits directly behind the biphase-to-NRZ decoder on the console receive path. It consumes the decoder's per-bit strobes, hunts for idle-line lock, and assembles UART-style frames: start 0, DATA_BITS data bits LSB-first, stop 1. Completed words go into a small FIFO with a valid/ready output. The block also reports lock status, frame errors and overflow to the console protocol layer.

## Interface
- DATA_BITS, 8: data bits per frame (1–16).
- IDLE_BITS, 10: consecutive marking (1) bits required to acquire lock.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.
- GLITCH_LIMIT, 15: glitch pulses tolerated within one frame.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  receive enable; low forces HUNT.
- bit_valid  in  1  one-cycle strobe: decoded bit available.
- bit_data  in  1  decoded NRZ bit, qualified by bit_valid.
- bit_ferr  in  1  one-cycle decoder framing-error strobe.
- bit_glitch  in  1  one-cycle decoder glitch strobe.
- rx_data  out  DATA_BITS  FIFO head word.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accept.
- locked  out  1  high in IDLE/DATA/PARITY/STOP.
- frame_error  out  1  one-cycle pulse per discarded frame or loss of lock.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- err_count  out  8  saturating count of frame_error pulses.
- clear_errors  in  1  one-cycle; zeroes err_count and overflow.

## Operation
- States: HUNT, IDLE, DATA, PARITY (macro only), STOP. Only bit_valid cycles advance the state machine; bit_ferr and enable can act on any cycle.
- HUNT: each bit_valid with 1 increments idle_cnt, and a 0 clears it. When idle_cnt reaches IDLE_BITS, go to IDLE and clear idle_cnt. In HUNT, bit_ferr clears idle_cnt and does not pulse frame_error.
- IDLE: bit 1 stays in IDLE. Bit 0 is the start bit: go to DATA with bit_idx=0 and glitch_cnt=0.
- DATA: shift the bit into shreg[bit_idx] and increment bit_idx. After bit DATA_BITS-1, go to PARITY (macro) or STOP.
- STOP: bit 1 pushes shreg to the FIFO and returns to IDLE. Bit 0 pulses frame_error and goes to HUNT.
- bit_ferr while locked: pulse frame_error, discard any partial word, go to HUNT. bit_ferr and bit_valid in the same cycle: bit_ferr wins and the bit is discarded.
- bit_glitch while in DATA/PARITY/STOP increments glitch_cnt. If glitch_cnt would exceed GLITCH_LIMIT, treat it as bit_ferr. Glitches in HUNT and IDLE are ignored.
- enable low: go to HUNT, clear idle_cnt, bit_idx and glitch_cnt, no frame_error pulse. The FIFO is retained and stays readable.
- FIFO:
  - Pop when rx_valid && rx_ready.
  - Push when not full. When full, a push is accepted only if a pop happens in the same cycle; otherwise the word is dropped and overflow is set.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. Full/empty come from the MSB compare.
- err_count: +1 per frame_error pulse, saturating at 255. clear_errors in the same cycle as an increment gives 0 (clear wins).

## Timing
- Reset values:
  - Outputs: rx_data=0, rx_valid=0, locked=0, frame_error=0, overflow=0, err_count=0.
  - Internal: state=HUNT, FIFO empty.
- Stop-bit strobe in cycle N: word is pushed at edge N+1, and rx_valid/rx_data are valid from cycle N+1.
- frame_error is registered: high exactly one cycle, the cycle after the causing strobe. err_count updates in the same cycle.
- locked follows state with one-cycle register latency.
- rx_data is the FIFO head (first-word fall-through) and is stable while rx_valid && !rx_ready.
- Reset mid-frame: partial word lost, FIFO emptied, no frame_error pulse.

## Configuration
- BIPHASE_RX_PARITY_EN defined: after the data bits, PARITY expects an even-parity bit over the data word.
  - Match: go to STOP.
  - Mismatch: pulse frame_error and go to HUNT.
- Undefined: no PARITY state; DATA goes straight to STOP, and frame length is DATA_BITS+2.

## Test plan
- Lock: 9 ones then 0 → still HUNT, locked=0. Then 10 ones → locked=1 after the tenth strobe plus 1 cycle.
- Good frame 0xA5 (start 0, 1,0,1,0,0,1,0,1, stop 1) → rx_data=0xA5, rx_valid=1 one cycle after the stop strobe. rx_ready=1 → rx_valid=0 next cycle.
- Stop bit 0 → frame_error one cycle, err_count=1, locked=0, FIFO unchanged.
- 5 frames with rx_ready=0 and FIFO_DEPTH=4 → 4 words held, overflow=1. clear_errors → overflow=0 and err_count=0. Draining yields the first 4 words in order.
- bit_ferr mid-DATA plus a simultaneous bit_valid → frame_error, HUNT, no push. 16 glitches in one frame → frame_error.
- With BIPHASE_RX_PARITY_EN: 0x03 with parity 0 → accepted. 0x03 with parity 1 → frame_error, no push.
